// File: rtl/fp_div_seq.sv
// Sequential Q16.16 signed divider: restoring radix-2, one quotient bit per clock, valid/ready on both sides.
// Define FP_DIV_ROUND_EN to compute one extra quotient bit and round half away from zero.
module fp_div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  div_by_zero,
  output logic                  overflow
);
  localparam int ITERS = DATA_WIDTH + FRAC_BITS;
`ifdef FP_DIV_ROUND_EN
  localparam int QBITS = ITERS + 1;
`else
  localparam int QBITS = ITERS;
`endif
  localparam int CW = $clog2(QBITS + 1);
  localparam logic [DATA_WIDTH-1:0] POS_SAT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_SAT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [QBITS:0] POS_LIM = {{(QBITS-DATA_WIDTH+1){1'b0}}, POS_SAT};
  localparam logic [QBITS:0] NEG_LIM = {{(QBITS-DATA_WIDTH+1){1'b0}}, NEG_SAT};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [DATA_WIDTH-1:0] divr_q, divr_d;
  logic [QBITS-1:0]      num_q, num_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [QBITS-1:0]      qm_q, qm_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic                  dz_q, dz_d;
  logic                  ov_q, ov_d;

  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  rem_ge;
  logic [QBITS:0]        qfin;

  assign mag_a  = dividend[DATA_WIDTH-1] ? -dividend : dividend;
  assign mag_b  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
  // Remainder stays below |b| <= 2^(W-1), so W bits hold it; the shifted trial needs W+1.
  assign rem_sh = {rem_q, num_q[QBITS-1]};
  assign rem_ge = rem_sh >= {1'b0, divr_q};
`ifdef FP_DIV_ROUND_EN
  assign qfin = ({1'b0, qm_q} + 1'b1) >> 1;
`else
  assign qfin = {1'b0, qm_q};
`endif

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = vld_q;
  assign quotient    = quo_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    divr_d  = divr_q;
    num_d   = num_q;
    rem_d   = rem_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    quo_d   = quo_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
          divr_d = mag_b;
          num_d  = {mag_a, {(QBITS-DATA_WIDTH){1'b0}}};
          rem_d  = '0;
          qm_d   = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            quo_d   = (dividend == '0) ? '0 :
                      (dividend[DATA_WIDTH-1] ? NEG_SAT : POS_SAT);
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == CW'(QBITS)) begin
          state_d = DONE;
          vld_d   = 1'b1;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          if (!sign_q && qfin > POS_LIM) begin
            quo_d = POS_SAT;
            ov_d  = 1'b1;
          end else if (sign_q && qfin > NEG_LIM) begin
            quo_d = NEG_SAT;
            ov_d  = 1'b1;
          end else begin
            quo_d = sign_q ? -qfin[DATA_WIDTH-1:0] : qfin[DATA_WIDTH-1:0];
          end
        end else begin
          num_d = num_q << 1;
          cnt_d = cnt_q + CW'(1);
          qm_d  = {qm_q[QBITS-2:0], rem_ge};
          rem_d = rem_ge ? DATA_WIDTH'(rem_sh - {1'b0, divr_q}) : rem_sh[DATA_WIDTH-1:0];
        end
      end
      DONE: begin
        // The divide-by-zero path enters DONE with valid low; raise it one clock later.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      divr_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      divr_q  <= divr_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq (honours FP_DIV_ROUND_EN when defined).
module tb_fp_div_seq;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        in_ready, out_valid, div_by_zero, overflow;
  logic [31:0] quotient;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef FP_DIV_ROUND_EN
  localparam int          LAT = 50;
  localparam logic [31:0] TWO_THIRDS = 32'h0000AAAB;
`else
  localparam int          LAT = 49;
  localparam logic [31:0] TWO_THIRDS = 32'h0000AAAA;
`endif

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from wide integer division, independent of the bit-serial datapath.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] ma, mb, q;
    logic        neg;
    r.dz = 1'b0;
    r.ov = 1'b0;
    ma = a[31] ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
    mb = b[31] ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
    if (b == 32'h0) begin
      r.dz = 1'b1;
      r.q  = (a == 32'h0) ? 32'h0 : (a[31] ? 32'h80000000 : 32'h7FFFFFFF);
      return r;
    end
    neg = a[31] ^ b[31];
`ifdef FP_DIV_ROUND_EN
    q = (((ma << 17) / mb) + 64'd1) >> 1;
`else
    q = (ma << 16) / mb;
`endif
    if (!neg && q > 64'h7FFFFFFF) begin
      r.q = 32'h7FFFFFFF; r.ov = 1'b1;
    end else if (neg && q > 64'h80000000) begin
      r.q = 32'h80000000; r.ov = 1'b1;
    end else begin
      r.q = neg ? 32'(64'h0 - q) : q[31:0];
    end
    return r;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic edz, input logic eov,
                        input int lat, input int hold);
    exp_t e;
    int   cyc;
    e.q = eq; e.dz = edz; e.ov = eov;
    sb.push_back(e);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("quotient", quotient, e.q);
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      chk("overflow", 32'(overflow), 32'(e.ov));
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_quotient", quotient, e.q);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t r;
    logic [31:0] a, b;
    logic        seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;

    run_op(32'h00060000, 32'h00020000, 32'h00030000, 1'b0, 1'b0, LAT, 10);
    run_op(32'h00020000, 32'h00030000, TWO_THIRDS,   1'b0, 1'b0, LAT, 0);
    run_op(32'hFFF88000, 32'h00028000, 32'hFFFD0000, 1'b0, 1'b0, LAT, 0);
    run_op(32'h00010000, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 1'b0, LAT, 0);
    run_op(32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 0);
    run_op(32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1, 0);
    run_op(32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1, 2);
    run_op(32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, LAT, 0);
    run_op(32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, LAT, 0);
    run_op(32'h80000000, 32'h0000FFFF, 32'h80000000, 1'b0, 1'b1, LAT, 0);

    // Abort an operation mid-calculation with reset.
    dividend = 32'h00060000; divisor = 32'h00020000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_valid_rst", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_output", 32'(seen), 32'd0);

    run_op(32'hFFF88000, 32'h00028000, 32'hFFFD0000, 1'b0, 1'b0, LAT, 0);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (i == 7) b = 32'h0;
      r = model(a, b);
      run_op(a, b, r.q, r.dz, r.ov, (b == 32'h0) ? 1 : LAT, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
